runctl: RTL and testbench

Run-control sequencer for the 16-bit stack CPU. It owns the CPU's global write enable: it holds the core in reset after power-up, then runs, halts, or single/multi-steps it under external command. It also stops execution on a hardware instruction-address breakpoint. It sits between the debug/host interface and the CPU top level:
- `o_cpuEn` gates every architectural write: IP, stack, SP, R, T and carry.
- `o_cpuRst` clears the core.

---
 rtl/runctl_pkg.sv | 24 ++
 rtl/runctl_stepcounter.sv | 30 +++
 rtl/runctl.sv | 140 ++++++++++++++
 tb/tb_runctl.sv | 286 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/runctl_pkg.sv
// Shared types and widths for the run-control sequencer of the 16-bit stack CPU.
package runctl_pkg;

  typedef enum logic [1:0] {
    ST_HOLD = 2'd0,
    ST_HALT = 2'd1,
    ST_RUN  = 2'd2,
    ST_STEP = 2'd3
  } run_state_t;

  localparam int ADDR_W  = 16;
  localparam int STEPN_W = 16;
  localparam int HOLD_W  = 4;

  // A step request of zero still executes one instruction.
  function automatic logic [STEPN_W-1:0] step_load_value(input logic [STEPN_W-1:0] n);
    if (n == {STEPN_W{1'b0}}) begin
      step_load_value = {{(STEPN_W-1){1'b0}}, 1'b1};
    end else begin
      step_load_value = n;
    end
  endfunction

endpackage

// File: rtl/runctl_stepcounter.sv
// Loadable down-counter holding the number of instructions still to execute in STEP.
module stepcounter
  import runctl_pkg::*;
(
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic [STEPN_W-1:0] load_value,
  input  logic               dec,
  output logic               is_one
);

  logic [STEPN_W-1:0] value_r;

  // Load has priority; decrement only while the core is actually stepping.
  always_ff @(posedge clock) begin
    if (reset) begin
      value_r <= {STEPN_W{1'b0}};
    end else if (load) begin
      value_r <= load_value;
    end else if (dec) begin
      value_r <= value_r - {{(STEPN_W-1){1'b0}}, 1'b1};
    end else begin
      value_r <= value_r;
    end
  end

  assign is_one = (value_r == {{(STEPN_W-1){1'b0}}, 1'b1});

endmodule

// File: rtl/runctl.sv
// Run-control sequencer: reset hold, run/halt/step commands and an instruction-address
// breakpoint, driving the CPU global write enable.
module runctl
  import runctl_pkg::*;
#(
  parameter int RESET_HOLD = 4,
  parameter int START_RUN  = 0,
  parameter int COUNT_W    = 32
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic               i_run,
  input  logic               i_halt,
  input  logic               i_step,
  input  logic [0:STEPN_W-1] i_stepN,
  input  logic [0:ADDR_W-1]  i_instrAddr,
  input  logic               i_bpWrite,
  input  logic [0:ADDR_W-1]  i_bpAddr,
  input  logic               i_bpEnable,
  output logic               o_cpuRst,
  output logic               o_cpuEn,
  output logic               o_halted,
  output logic               o_bpHit,
  output logic [0:COUNT_W-1] o_instrCount
);

  localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(RESET_HOLD - 1);
  localparam run_state_t        HOLD_EXIT = (START_RUN != 0) ? ST_RUN : ST_HALT;

  run_state_t         state_r;
  logic [HOLD_W-1:0]  hold_cnt_r;
  logic [ADDR_W-1:0]  bp_addr_r;
  logic               bp_en_r;
  logic               skip_r;
  logic               cpu_rst_r;
  logic               halted_r;
  logic               bp_hit_r;
  logic [COUNT_W-1:0] instr_count_r;

  logic               active_s;
  logic               bp_match_s;
  logic               cpu_en_s;
  logic               step_load_s;
  logic               step_dec_s;
  logic               last_step_s;
  logic [STEPN_W-1:0] step_value_s;

  // skip masks the breakpoint for the first executed instruction after a resume.
  assign active_s    = (state_r == ST_RUN) || (state_r == ST_STEP);
  assign bp_match_s  = active_s & bp_en_r & (i_instrAddr == bp_addr_r) & ~skip_r;
  assign cpu_en_s    = active_s & ~bp_match_s;
  assign step_load_s = (state_r == ST_HALT) & ~i_halt & ~i_run & i_step;
  assign step_dec_s  = (state_r == ST_STEP) & cpu_en_s;
  assign step_value_s = step_load_value(i_stepN);

  stepcounter u_remaining (
    .clock      (i_clock),
    .reset      (i_reset),
    .load       (step_load_s),
    .load_value (step_value_s),
    .dec        (step_dec_s),
    .is_one     (last_step_s)
  );

  // Sequencer state and its registered status outputs.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      state_r    <= ST_HOLD;
      hold_cnt_r <= {HOLD_W{1'b0}};
      cpu_rst_r  <= 1'b1;
      halted_r   <= 1'b0;
      bp_hit_r   <= 1'b0;
      skip_r     <= 1'b0;
    end else begin
      case (state_r)
        ST_HOLD: begin
          if (hold_cnt_r == HOLD_LAST) begin
            state_r   <= HOLD_EXIT;
            cpu_rst_r <= 1'b0;
            halted_r  <= (HOLD_EXIT == ST_HALT);
          end else begin
            hold_cnt_r <= hold_cnt_r + {{(HOLD_W-1){1'b0}}, 1'b1};
          end
        end
        ST_HALT: begin
          if (i_halt) begin
            state_r <= ST_HALT;
          end else if (i_run || i_step) begin
            state_r  <= i_run ? ST_RUN : ST_STEP;
            skip_r   <= 1'b1;
            bp_hit_r <= 1'b0;
            halted_r <= 1'b0;
          end
        end
        ST_RUN, ST_STEP: begin
          if (cpu_en_s) begin
            skip_r <= 1'b0;
          end
          // A breakpoint beats both a halt request and the final step.
          if (bp_match_s) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
            bp_hit_r <= 1'b1;
          end else if (i_halt || ((state_r == ST_STEP) && last_step_s)) begin
            state_r  <= ST_HALT;
            halted_r <= 1'b1;
          end
        end
        default: begin
          state_r    <= ST_HOLD;
          hold_cnt_r <= {HOLD_W{1'b0}};
          cpu_rst_r  <= 1'b1;
          halted_r   <= 1'b0;
        end
      endcase
    end
  end

  // Breakpoint registers and the executed-instruction counter.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      bp_addr_r     <= {ADDR_W{1'b0}};
      bp_en_r       <= 1'b0;
      instr_count_r <= {COUNT_W{1'b0}};
    end else begin
      if (i_bpWrite) begin
        bp_addr_r <= i_bpAddr;
        bp_en_r   <= i_bpEnable;
      end
      instr_count_r <= instr_count_r + {{(COUNT_W-1){1'b0}}, cpu_en_s};
    end
  end

  assign o_cpuRst     = cpu_rst_r;
  assign o_cpuEn      = cpu_en_s;
  assign o_halted     = halted_r;
  assign o_bpHit      = bp_hit_r;
  assign o_instrCount = instr_count_r;

endmodule

// File: tb/tb_runctl.sv
// Self-checking bench for runctl: directed scenarios plus a randomized run against a
// cycle-level behavioural model of the run-control rules.
module tb_runctl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset, run, halt, step, bp_write, bp_en;
  logic [15:0] step_n, ip, bp_addr;
  logic        cpu_rst, cpu_en, halted, bp_hit;
  logic [31:0] count;

  logic        reset2;
  logic        z1 = 1'b0;
  logic [15:0] z16 = 16'h0000;
  logic        cpu_rst2, cpu_en2, halted2, bp_hit2;
  logic [3:0]  count2;

  int n_checks = 0;
  int n_pass   = 0;

  runctl #(.RESET_HOLD(4), .START_RUN(0), .COUNT_W(32)) dut (
    .i_clock(clk), .i_reset(reset), .i_run(run), .i_halt(halt), .i_step(step),
    .i_stepN(step_n), .i_instrAddr(ip), .i_bpWrite(bp_write), .i_bpAddr(bp_addr),
    .i_bpEnable(bp_en), .o_cpuRst(cpu_rst), .o_cpuEn(cpu_en), .o_halted(halted),
    .o_bpHit(bp_hit), .o_instrCount(count)
  );

  runctl #(.RESET_HOLD(2), .START_RUN(1), .COUNT_W(4)) dut_wrap (
    .i_clock(clk), .i_reset(reset2), .i_run(z1), .i_halt(z1), .i_step(z1),
    .i_stepN(z16), .i_instrAddr(z16), .i_bpWrite(z1), .i_bpAddr(z16),
    .i_bpEnable(z1), .o_cpuRst(cpu_rst2), .o_cpuEn(cpu_en2), .o_halted(halted2),
    .o_bpHit(bp_hit2), .o_instrCount(count2)
  );

  // Reference model of the main instance (mode: 0 hold, 1 halted, 2 running, 3 stepping).
  int          m_mode, m_hold_left, m_left;
  bit          m_rst, m_halted, m_hit, m_skip, m_bpe;
  logic [15:0] m_bpa;
  logic [31:0] m_count;

  function automatic bit m_en();
    return (m_mode >= 2) && !(m_bpe && (ip == m_bpa) && !m_skip);
  endfunction

  task automatic model_advance();
    bit match, en;
    if (reset) begin
      m_mode = 0; m_hold_left = 4; m_rst = 1'b1; m_halted = 1'b0; m_hit = 1'b0;
      m_count = 32'd0; m_bpa = 16'h0000; m_bpe = 1'b0; m_left = 0; m_skip = 1'b0;
      return;
    end
    match = (m_mode >= 2) && m_bpe && (ip == m_bpa) && !m_skip;
    en    = (m_mode >= 2) && !match;
    if (en) begin
      m_count = m_count + 32'd1;
      m_skip  = 1'b0;
    end
    if (m_mode == 0) begin
      m_hold_left = m_hold_left - 1;
      if (m_hold_left == 0) begin m_mode = 1; m_rst = 1'b0; m_halted = 1'b1; end
    end else if (m_mode == 1) begin
      if (!halt && (run || step)) begin
        m_mode = run ? 2 : 3;
        if (!run) m_left = (step_n == 16'd0) ? 1 : int'(step_n);
        m_skip = 1'b1; m_hit = 1'b0; m_halted = 1'b0;
      end
    end else begin
      if (match) begin
        m_mode = 1; m_halted = 1'b1; m_hit = 1'b1;
      end else begin
        if (m_mode == 3) m_left = m_left - 1;
        if (halt || (m_mode == 3 && m_left == 0)) begin m_mode = 1; m_halted = 1'b1; end
      end
    end
    if (bp_write) begin m_bpa = bp_addr; m_bpe = bp_en; end
  endtask

  task automatic clk_cycle();
    @(posedge clk);
    model_advance();
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) clk_cycle();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #2;
      n_checks++; if (cpu_rst !== 1'b1) $display("FAIL hold_rst cycle %0d got=%b exp=1", i, cpu_rst); else n_pass++;
      n_checks++; if (cpu_en !== 1'b0) $display("FAIL hold_en cycle %0d got=%b exp=0", i, cpu_en); else n_pass++;
      clk_cycle();
    end
    #2;
    n_checks++; if (cpu_rst !== 1'b0) $display("FAIL post_hold_rst got=%b exp=0", cpu_rst); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL post_hold_halted got=%b exp=1", halted); else n_pass++;
    n_checks++; if (cpu_en !== 1'b0) $display("FAIL post_hold_en got=%b exp=0", cpu_en); else n_pass++;
    n_checks++; if (count !== 32'd0) $display("FAIL post_hold_count got=%0d exp=0", count); else n_pass++;
    n_checks++; if (bp_hit !== 1'b0) $display("FAIL post_hold_bphit got=%b exp=0", bp_hit); else n_pass++;
  endtask

  task automatic test_step();
    int en_cycles;
    logic [15:0] reqs [2];
    int exp_en [2];
    int exp_count;
    reqs[0] = 16'd5; reqs[1] = 16'd0; exp_en[0] = 5; exp_en[1] = 1;
    exp_count = 0;
    for (int t = 0; t < 2; t++) begin
      step = 1'b1; step_n = reqs[t];
      clk_cycle();
      step = 1'b0; en_cycles = 0;
      for (int i = 0; i < 8; i++) begin
        ip = 16'($urandom);
        #2;
        if (i == 0) begin
          n_checks++; if (cpu_en !== 1'b1) $display("FAIL step_latency n=%0d got=%b exp=1", reqs[t], cpu_en); else n_pass++;
        end
        if (cpu_en === 1'b1) en_cycles++;
        clk_cycle();
      end
      exp_count = exp_count + exp_en[t];
      #2;
      n_checks++; if (en_cycles !== exp_en[t]) $display("FAIL step_cycles n=%0d got=%0d exp=%0d", reqs[t], en_cycles, exp_en[t]); else n_pass++;
      n_checks++; if (count !== 32'(exp_count)) $display("FAIL step_count got=%0d exp=%0d", count, exp_count); else n_pass++;
      n_checks++; if (halted !== 1'b1) $display("FAIL step_halted got=%b exp=1", halted); else n_pass++;
    end
  endtask

  task automatic test_breakpoint();
    logic [15:0] stop_ip;
    reset = 1'b1; clk_cycle(); reset = 1'b0;
    repeat (4) clk_cycle();
    bp_write = 1'b1; bp_addr = 16'h0010; bp_en = 1'b1;
    clk_cycle();
    bp_write = 1'b0; ip = 16'h0000; run = 1'b1;
    clk_cycle();
    run = 1'b0; stop_ip = 16'hffff;
    for (int i = 0; i < 40; i++) begin
      #2;
      if (cpu_en !== 1'b1) begin stop_ip = ip; break; end
      clk_cycle();
      ip = ip + 16'd1;
    end
    n_checks++; if (stop_ip !== 16'h0010) $display("FAIL bp_stop_addr got=%h exp=0010", stop_ip); else n_pass++;
    clk_cycle();
    #2;
    n_checks++; if (halted !== 1'b1) $display("FAIL bp_halted got=%b exp=1", halted); else n_pass++;
    n_checks++; if (bp_hit !== 1'b1) $display("FAIL bp_hit got=%b exp=1", bp_hit); else n_pass++;
    n_checks++; if (count !== 32'd16) $display("FAIL bp_count got=%0d exp=16", count); else n_pass++;
    run = 1'b1; clk_cycle(); run = 1'b0;
    #2;
    n_checks++; if (cpu_en !== 1'b1) $display("FAIL bp_resume_en got=%b exp=1", cpu_en); else n_pass++;
    n_checks++; if (bp_hit !== 1'b0) $display("FAIL bp_resume_hit got=%b exp=0", bp_hit); else n_pass++;
  endtask

  task automatic test_halt();
    clk_cycle();
    ip = 16'h0011; halt = 1'b1;
    #2;
    n_checks++; if (cpu_en !== 1'b1) $display("FAIL halt_cycle_en got=%b exp=1", cpu_en); else n_pass++;
    clk_cycle();
    halt = 1'b0;
    #2;
    n_checks++; if (cpu_en !== 1'b0) $display("FAIL halt_after_en got=%b exp=0", cpu_en); else n_pass++;
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_after_halted got=%b exp=1", halted); else n_pass++;
    n_checks++; if (count !== 32'd18) $display("FAIL halt_count got=%0d exp=18", count); else n_pass++;
    halt = 1'b1; run = 1'b1;
    clk_cycle();
    halt = 1'b0; run = 1'b0;
    #2;
    n_checks++; if (halted !== 1'b1) $display("FAIL halt_run_prio got=%b exp=1", halted); else n_pass++;
    n_checks++; if (cpu_en !== 1'b0) $display("FAIL halt_run_en got=%b exp=0", cpu_en); else n_pass++;
  endtask

  task automatic test_step_bp();
    int en_cycles;
    bit e;
    bp_write = 1'b1; bp_addr = 16'h0102; bp_en = 1'b1;
    clk_cycle();
    bp_write = 1'b0; ip = 16'h0100; step = 1'b1; step_n = 16'd3;
    clk_cycle();
    step = 1'b0; en_cycles = 0;
    for (int i = 0; i < 6; i++) begin
      #2;
      e = m_en();
      if (cpu_en === 1'b1) en_cycles++;
      clk_cycle();
      if (e) ip = ip + 16'd1;
    end
    #2;
    n_checks++; if (en_cycles !== 2) $display("FAIL stepbp_cycles got=%0d exp=2", en_cycles); else n_pass++;
    n_checks++; if (bp_hit !== 1'b1) $display("FAIL stepbp_hit got=%b exp=1", bp_hit); else n_pass++;
    n_checks++; if (count !== 32'd20) $display("FAIL stepbp_count got=%0d exp=20", count); else n_pass++;
  endtask

  task automatic test_reset_midstep();
    step = 1'b1; step_n = 16'd100;
    clk_cycle();
    step = 1'b0;
    repeat (10) begin ip = 16'($urandom_range(16'h0200, 16'h02ff)); clk_cycle(); end
    #2;
    n_checks++; if (cpu_en !== 1'b1) $display("FAIL midstep_en got=%b exp=1", cpu_en); else n_pass++;
    reset = 1'b1;
    clk_cycle();
    reset = 1'b0;
    #2;
    n_checks++; if (cpu_rst !== 1'b1) $display("FAIL midrst_rst got=%b exp=1", cpu_rst); else n_pass++;
    n_checks++; if (cpu_en !== 1'b0) $display("FAIL midrst_en got=%b exp=0", cpu_en); else n_pass++;
    n_checks++; if (halted !== 1'b0) $display("FAIL midrst_halted got=%b exp=0", halted); else n_pass++;
    n_checks++; if (bp_hit !== 1'b0) $display("FAIL midrst_bphit got=%b exp=0", bp_hit); else n_pass++;
    n_checks++; if (count !== 32'd0) $display("FAIL midrst_count got=%0d exp=0", count); else n_pass++;
    repeat (4) clk_cycle();
    run = 1'b1; clk_cycle(); run = 1'b0;
    ip = 16'h0200; clk_cycle();
    ip = 16'h0102;
    #2;
    n_checks++; if (cpu_en !== 1'b1) $display("FAIL midrst_bp_cleared got=%b exp=1", cpu_en); else n_pass++;
    halt = 1'b1; clk_cycle(); halt = 1'b0;
  endtask

  task automatic test_wrap();
    int en2_cycles;
    reset2 = 1'b1; clk_cycle(); reset2 = 1'b0;
    for (int i = 0; i < 2; i++) begin
      #2;
      n_checks++; if (cpu_rst2 !== 1'b1) $display("FAIL wrap_hold cycle %0d got=%b exp=1", i, cpu_rst2); else n_pass++;
      clk_cycle();
    end
    en2_cycles = 0;
    for (int i = 0; i < 16; i++) begin
      #2;
      if (i == 0) begin
        n_checks++; if (cpu_rst2 !== 1'b0 || halted2 !== 1'b0) $display("FAIL wrap_start rst=%b halted=%b exp=0,0", cpu_rst2, halted2); else n_pass++;
      end
      if (i == 15) begin
        n_checks++; if (count2 !== 4'd15) $display("FAIL wrap_pre got=%0d exp=15", count2); else n_pass++;
      end
      if (cpu_en2 === 1'b1) en2_cycles++;
      clk_cycle();
    end
    #2;
    n_checks++; if (en2_cycles !== 16) $display("FAIL wrap_cycles got=%0d exp=16", en2_cycles); else n_pass++;
    n_checks++; if (count2 !== 4'd0) $display("FAIL wrap_count got=%0d exp=0", count2); else n_pass++;
    n_checks++; if (bp_hit2 !== 1'b0) $display("FAIL wrap_bphit got=%b exp=0", bp_hit2); else n_pass++;
  endtask

  task automatic test_random();
    for (int i = 0; i < 800; i++) begin
      reset    = ($urandom_range(0, 99) == 0);
      run      = ($urandom_range(0, 9) == 0);
      halt     = ($urandom_range(0, 11) == 0);
      step     = ($urandom_range(0, 7) == 0);
      step_n   = 16'($urandom_range(0, 6));
      ip       = 16'($urandom_range(0, 7));
      bp_write = ($urandom_range(0, 15) == 0);
      bp_addr  = 16'($urandom_range(0, 7));
      bp_en    = 1'($urandom_range(0, 1));
      #2;
      n_checks++; if (cpu_rst !== m_rst) $display("FAIL rnd_rst cycle %0d got=%b exp=%b", i, cpu_rst, m_rst); else n_pass++;
      n_checks++; if (cpu_en !== m_en()) $display("FAIL rnd_en cycle %0d got=%b exp=%b", i, cpu_en, m_en()); else n_pass++;
      n_checks++; if (halted !== m_halted) $display("FAIL rnd_halted cycle %0d got=%b exp=%b", i, halted, m_halted); else n_pass++;
      n_checks++; if (bp_hit !== m_hit) $display("FAIL rnd_bphit cycle %0d got=%b exp=%b", i, bp_hit, m_hit); else n_pass++;
      n_checks++; if (count !== m_count) $display("FAIL rnd_count cycle %0d got=%0d exp=%0d", i, count, m_count); else n_pass++;
      clk_cycle();
    end
    reset = 1'b0; run = 1'b0; halt = 1'b0; step = 1'b0; bp_write = 1'b0;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; halt = 1'b0; step = 1'b0; bp_write = 1'b0; bp_en = 1'b0;
    step_n = 16'd0; ip = 16'd0; bp_addr = 16'd0; reset2 = 1'b1;
    test_reset();
    test_step();
    test_breakpoint();
    test_halt();
    test_step_bp();
    test_reset_midstep();
    test_wrap();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
